// File: rtl/icache_direct.sv
`default_nettype none
// ============================================================================
// Module   : icache_direct
// Purpose  : Direct-mapped, one-word-per-block instruction cache for a single
//            core. Hits are served combinationally. Misses are filled over
//            the memory controller's iREN/iaddr/iwait/iload handshake. Hit
//            and miss counters are kept for performance reporting.
// Ports    : CLK, nRST            - clock, synchronous active-low reset
//            imemREN, imemaddr    - fetch request from the datapath
//            ihit, imemload       - fetch result (imemload valid when ihit)
//            flush                - invalidate all entries
//            iREN, iaddr          - read request to the memory controller
//            iwait, iload         - controller stall and read data
//            hit_count,miss_count - performance counters (wrap on overflow)
// Revision : 1.0 - initial release
// ============================================================================
module icache_direct #(
    parameter int SETS = 16,
    parameter int CTRW = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            imemREN,
    input  logic [31:0]     imemaddr,
    output logic            ihit,
    output logic [31:0]     imemload,
    input  logic            flush,
    output logic            iREN,
    output logic [31:0]     iaddr,
    input  logic            iwait,
    input  logic [31:0]     iload,
    output logic [CTRW-1:0] hit_count,
    output logic [CTRW-1:0] miss_count
);

    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Only the valid bits carry reset; tag and data are qualified by valid.
    logic [SETS-1:0]    r_valid;
    logic [TAGW-1:0]    r_tag  [SETS];
    logic [31:0]        r_data [SETS];

    // Word address of the outstanding miss.
    logic [29:0]        r_fill_addr;
    logic [CTRW-1:0]    r_hit_count;
    logic [CTRW-1:0]    r_miss_count;

    logic [IDX-1:0]     w_index;
    logic [TAGW-1:0]    w_tag;
    logic               w_lookup_hit;
    logic               w_hit_inc;
    logic               w_miss;
    logic               w_fill_we;
    logic [IDX-1:0]     w_fill_index;
    logic [TAGW-1:0]    w_fill_tag;

    // Byte-offset bits of the fetch address play no part in the lookup.
    logic               w_unused;
    assign w_unused = &{1'b0, imemaddr[1:0]};

    assign w_index      = imemaddr[IDX+1:2];
    assign w_tag        = imemaddr[31:IDX+2];
    assign w_lookup_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_fill_index = r_fill_addr[IDX-1:0];
    assign w_fill_tag   = r_fill_addr[29:IDX];

    assign hit_count    = r_hit_count;
    assign miss_count   = r_miss_count;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        ihit         = 1'b0;
        imemload     = 32'h0;
        iREN         = 1'b0;
        iaddr        = 32'h0;
        w_hit_inc    = 1'b0;
        w_miss       = 1'b0;
        w_fill_we    = 1'b0;

        case (r_state)
            IDLE: begin
                if (imemREN) begin
                    if (w_lookup_hit) begin
                        ihit      = 1'b1;
                        imemload  = r_data[w_index];
                        w_hit_inc = 1'b1;
                    end else begin
                        w_miss       = 1'b1;
                        w_state_next = FILL;
                    end
                end
            end
            FILL: begin
                // The request is held regardless of what the datapath does,
                // so the controller never sees a withdrawn read.
                iREN  = 1'b1;
                iaddr = {r_fill_addr, 2'b00};
                if (!iwait) begin
                    w_fill_we    = 1'b1;
                    w_state_next = IDLE;
                    // Forward the returning word only if the datapath is
                    // still asking for the same address; not counted as a hit.
                    if (imemREN && (imemaddr[31:2] == r_fill_addr)) begin
                        ihit     = 1'b1;
                        imemload = iload;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, fill address and counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_fill_addr  <= 30'h0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_miss) begin
                r_fill_addr  <= imemaddr[31:2];
                r_miss_count <= r_miss_count + 1'b1;
            end
            if (w_hit_inc) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
        end
    end

    // Flush takes priority over a same-cycle fill so the filled entry ends
    // up invalid; its tag/data may still be written but are never used.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_fill_we) begin
            r_valid[w_fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && w_fill_we) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= iload;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_direct
// Purpose  : Directed self-checking bench for icache_direct.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_direct;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int nchecks = 0;
    int npass   = 0;

    icache_direct #(.SETS(16), .CTRW(32)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .flush      (flush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        flush    = 1'b0;
        iwait    = 1'b1;
        iload    = 32'h0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    // Zero-wait fill: miss cycle, then one FILL cycle with iwait=0.
    task automatic do_fill(input logic [31:0] a, input logic [31:0] d);
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        tick();
        iwait = 1'b0;
        iload = d;
        tick();
        imemREN = 1'b0;
        iwait   = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        #1;
        nchecks++; if (iREN !== 1'b0) $display("FAIL reset_iREN: got %b expected 0", iREN); else npass++;
        nchecks++; if (iaddr !== 32'h0) $display("FAIL reset_iaddr: got %h expected 0", iaddr); else npass++;
        nchecks++; if (ihit !== 1'b0) $display("FAIL reset_ihit: got %b expected 0", ihit); else npass++;
        nchecks++; if (imemload !== 32'h0) $display("FAIL reset_imemload: got %h expected 0", imemload); else npass++;
        nchecks++; if (hit_count !== 32'd0) $display("FAIL reset_hits: got %0d expected 0", hit_count); else npass++;
        nchecks++; if (miss_count !== 32'd0) $display("FAIL reset_misses: got %0d expected 0", miss_count); else npass++;
    endtask

    task automatic test_cold_miss();
        reset_dut();
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        iwait    = 1'b1;
        iload    = 32'h2401_0005;
        #1;
        nchecks++; if (ihit !== 1'b0) $display("FAIL cold_lookup_ihit: got %b expected 0", ihit); else npass++;
        nchecks++; if (iREN !== 1'b0) $display("FAIL cold_lookup_iREN: got %b expected 0", iREN); else npass++;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            nchecks++; if (iREN !== 1'b1) $display("FAIL cold_wait_iREN[%0d]: got %b expected 1", i, iREN); else npass++;
            nchecks++; if (iaddr !== 32'h40) $display("FAIL cold_wait_iaddr[%0d]: got %h expected 40", i, iaddr); else npass++;
            nchecks++; if (ihit !== 1'b0) $display("FAIL cold_wait_ihit[%0d]: got %b expected 0", i, ihit); else npass++;
            tick();
        end
        iwait = 1'b0;
        #1;
        nchecks++; if (iREN !== 1'b1) $display("FAIL cold_done_iREN: got %b expected 1", iREN); else npass++;
        nchecks++; if (iaddr !== 32'h40) $display("FAIL cold_done_iaddr: got %h expected 40", iaddr); else npass++;
        nchecks++; if (ihit !== 1'b1) $display("FAIL cold_fwd_ihit: got %b expected 1", ihit); else npass++;
        nchecks++; if (imemload !== 32'h2401_0005) $display("FAIL cold_fwd_data: got %h expected 24010005", imemload); else npass++;
        tick();
        iwait = 1'b1;
        iload = 32'hDEAD_BEEF;
        #1;
        nchecks++; if (ihit !== 1'b1) $display("FAIL cold_rehit_ihit: got %b expected 1", ihit); else npass++;
        nchecks++; if (iREN !== 1'b0) $display("FAIL cold_rehit_iREN: got %b expected 0", iREN); else npass++;
        nchecks++; if (imemload !== 32'h2401_0005) $display("FAIL cold_rehit_data: got %h expected 24010005", imemload); else npass++;
        tick();
        imemREN = 1'b0;
        #1;
        nchecks++; if (hit_count !== 32'd1) $display("FAIL cold_hits: got %0d expected 1", hit_count); else npass++;
        nchecks++; if (miss_count !== 32'd1) $display("FAIL cold_misses: got %0d expected 1", miss_count); else npass++;
    endtask

    task automatic test_conflict();
        reset_dut();
        do_fill(32'h0000_0004, 32'h1111_0004);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0044;
        #1;
        nchecks++; if (ihit !== 1'b0) $display("FAIL conflict_44_ihit: got %b expected 0", ihit); else npass++;
        tick();
        iwait = 1'b0;
        iload = 32'h2222_0044;
        tick();
        iwait    = 1'b1;
        imemaddr = 32'h0000_0004;
        #1;
        nchecks++; if (ihit !== 1'b0) $display("FAIL conflict_04_ihit: got %b expected 0", ihit); else npass++;
        tick();
        iwait = 1'b0;
        iload = 32'h1111_0004;
        tick();
        iwait   = 1'b1;
        imemREN = 1'b0;
        #1;
        nchecks++; if (miss_count !== 32'd3) $display("FAIL conflict_misses: got %0d expected 3", miss_count); else npass++;
        nchecks++; if (hit_count !== 32'd0) $display("FAIL conflict_hits: got %0d expected 0", hit_count); else npass++;
    endtask

    task automatic test_withdrawn();
        reset_dut();
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        tick();
        imemREN  = 1'b0;
        imemaddr = 32'h0000_1234;
        for (int i = 0; i < 2; i++) begin
            #1;
            nchecks++; if (iREN !== 1'b1) $display("FAIL wd_iREN[%0d]: got %b expected 1", i, iREN); else npass++;
            nchecks++; if (iaddr !== 32'h80) $display("FAIL wd_iaddr[%0d]: got %h expected 80", i, iaddr); else npass++;
            nchecks++; if (ihit !== 1'b0) $display("FAIL wd_ihit[%0d]: got %b expected 0", i, ihit); else npass++;
            tick();
        end
        // Different address requested in the completion cycle: no forward.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0084;
        iwait    = 1'b0;
        iload    = 32'hCAFE_0080;
        #1;
        nchecks++; if (iaddr !== 32'h80) $display("FAIL wd_done_iaddr: got %h expected 80", iaddr); else npass++;
        nchecks++; if (ihit !== 1'b0) $display("FAIL wd_done_ihit: got %b expected 0", ihit); else npass++;
        tick();
        iwait    = 1'b1;
        imemaddr = 32'h0000_0080;
        #1;
        nchecks++; if (ihit !== 1'b1) $display("FAIL wd_refetch_ihit: got %b expected 1", ihit); else npass++;
        nchecks++; if (imemload !== 32'hCAFE_0080) $display("FAIL wd_refetch_data: got %h expected cafe0080", imemload); else npass++;
        tick();
        imemREN = 1'b0;
    endtask

    task automatic test_flush();
        reset_dut();
        do_fill(32'h00, 32'hD000_0000);
        do_fill(32'h04, 32'hD000_0004);
        do_fill(32'h08, 32'hD000_0008);
        // Lookup in the flush cycle still sees pre-flush contents.
        imemREN  = 1'b1;
        imemaddr = 32'h04;
        flush    = 1'b1;
        #1;
        nchecks++; if (ihit !== 1'b1) $display("FAIL flush_cycle_ihit: got %b expected 1", ihit); else npass++;
        nchecks++; if (imemload !== 32'hD000_0004) $display("FAIL flush_cycle_data: got %h expected d0000004", imemload); else npass++;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imemREN  = 1'b1;
            imemaddr = 32'(i * 4);
            #1;
            nchecks++; if (ihit !== 1'b0) $display("FAIL flush_miss_ihit[%0d]: got %b expected 0", i, ihit); else npass++;
            tick();
            iwait = 1'b0;
            iload = 32'hD000_0000 + 32'(i * 4);
            tick();
            iwait = 1'b1;
        end
        // Flush in the completing fill cycle leaves the entry invalid.
        imemaddr = 32'h0C;
        tick();
        iwait = 1'b0;
        iload = 32'hE000_000C;
        flush = 1'b1;
        #1;
        nchecks++; if (ihit !== 1'b1) $display("FAIL flush_fill_fwd_ihit: got %b expected 1", ihit); else npass++;
        tick();
        flush = 1'b0;
        iwait = 1'b1;
        #1;
        nchecks++; if (ihit !== 1'b0) $display("FAIL flush_fill_invalid_ihit: got %b expected 0", ihit); else npass++;
        tick();
        iwait = 1'b0;
        tick();
        iwait   = 1'b1;
        imemREN = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        reset_dut();
        do_fill(32'h0000_0010, 32'h5555_0010);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0100;
        tick();
        tick();
        // Reset edge coincides with a would-be completion.
        nRST  = 1'b0;
        iwait = 1'b0;
        iload = 32'h7777_0100;
        tick();
        nRST    = 1'b1;
        iwait   = 1'b1;
        imemREN = 1'b0;
        #1;
        nchecks++; if (iREN !== 1'b0) $display("FAIL rmf_iREN: got %b expected 0", iREN); else npass++;
        nchecks++; if (ihit !== 1'b0) $display("FAIL rmf_ihit: got %b expected 0", ihit); else npass++;
        nchecks++; if (hit_count !== 32'd0) $display("FAIL rmf_hits: got %0d expected 0", hit_count); else npass++;
        nchecks++; if (miss_count !== 32'd0) $display("FAIL rmf_misses: got %0d expected 0", miss_count); else npass++;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0100;
        #1;
        nchecks++; if (ihit !== 1'b0) $display("FAIL rmf_refetch_ihit: got %b expected 0", ihit); else npass++;
        tick();
        iwait = 1'b0;
        tick();
        iwait   = 1'b1;
        imemREN = 1'b0;
    endtask

    task automatic test_hit_streak();
        int ren_cycles;
        ren_cycles = 0;
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            do_fill(32'(i * 4), 32'hA000_0000 + 32'(i));
        end
        iwait = 1'b1;
        for (int i = 0; i < 16; i++) begin
            imemREN  = 1'b1;
            imemaddr = 32'(i * 4);
            #1;
            if (iREN) ren_cycles++;
            nchecks++; if (ihit !== 1'b1) $display("FAIL streak_ihit[%0d]: got %b expected 1", i, ihit); else npass++;
            nchecks++; if (imemload !== (32'hA000_0000 + 32'(i))) $display("FAIL streak_data[%0d]: got %h expected %h", i, imemload, 32'hA000_0000 + 32'(i)); else npass++;
            tick();
        end
        imemREN = 1'b0;
        #1;
        nchecks++; if (ren_cycles !== 0) $display("FAIL streak_iREN_cycles: got %0d expected 0", ren_cycles); else npass++;
        nchecks++; if (hit_count !== 32'd16) $display("FAIL streak_hits: got %0d expected 16", hit_count); else npass++;
        nchecks++; if (miss_count !== 32'd16) $display("FAIL streak_misses: got %0d expected 16", miss_count); else npass++;
    endtask

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        flush    = 1'b0;
        iwait    = 1'b1;
        iload    = 32'h0;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_withdrawn();
        test_flush();
        test_reset_mid_fill();
        test_hit_streak();
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
`default_nettype wire
